std_conv: RTL and testbench
===========================

// Module: std_conv
// PURPOSE
//  Standard (dense) 2-D convolution engine: on PS start, reads N-channel iFM and MxN KxK kernels from one
//  shared BRAM port, computes M valid-mode output maps (stride 1, no padding), writes them back to BRAM.
//  Sits between the PS control/status registers and a single 32-bit word BRAM; sole BRAM master while busy.
// PARAMETERS
//  N          2                    iFM depth (input channels)
//  M          2                    oFM depth (output channels / kernel count)
//  K          3                    square kernel size (KR=KC=K)
//  IFM_R      15                   iFM rows;  IFM_C 15 = iFM cols
//  OFM_R/OFM_C IFM_R-K+1/IFM_C-K+1 output dims (derived, 13x13)
//  IFM_BASE   0                    iFM start, word index
//  KERN_BASE  IFM_BASE+N*IFM_R*IFM_C   kernel start, word index (450)
//  OFM_BASE   KERN_BASE+K*K*M*N    oFM start, word index (486)
// PORTS
//  clk          in   1   single system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  ps_control   in   32  bit0 = start (level); bits 31:1 ignored
//  pl_status    out  32  bit0 = done; bits 31:1 always 0
//  BRAM_addr    out  32  byte address = word index*4; bits 1:0 always 0
//  BRAM_rddata  in   32  read data, valid 1 cycle after address is sampled
//  BRAM_wrdata  out  32  write data
//  BRAM_we      out  4   4'hF = full-word write, else 4'h0 (no partial writes)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE, accumulator/counters cleared; mid-operation reset aborts immediately.
//  - Layouts (word-indexed, row-major): iFM[n][r][c] at IFM_BASE+(n*IFM_R+r)*IFM_C+c;
//    W[m][n][i][j] at KERN_BASE+((m*N+n)*K+i)*K+j; oFM[m][r][c] at OFM_BASE+(m*OFM_R+r)*OFM_C+c.
//  - oFM[m][r][c] = sum_n sum_i sum_j iFM[n][r+i][c+j]*W[m][n][i][j]; 32-bit two's complement,
//    products truncated to 32 bits, accumulation wraps modulo 2^32.
//  - Loop order: m outer, then r, c; per output pixel n, i, j inner. Accumulator cleared per pixel.
//  - FSM: IDLE -(ps_control[0]=1)-> RD_IFM -> RD_W -> MAC (repeat N*K*K) -> WRITE -> next pixel
//    or DONE after last pixel of last map. DONE: pl_status[0]=1; hold until ps_control[0]=0, then
//    pl_status[0]=0 and -> IDLE (no restart while start stays high).
//  - Read: drive BRAM_addr for one cycle with we=0; capture BRAM_rddata on the following cycle.
//  - Write: one cycle with BRAM_we=4'hF, BRAM_addr=oFM address, BRAM_wrdata=accumulator; we=0 otherwise.
//  - Deassertion of ps_control[0] while busy is ignored; job always completes.
//  - Never writes outside oFM region; iFM/kernel regions read-only.
//  - BRAM_addr/wrdata/we registered outputs; no combinational path from inputs.
// TESTING
//  - Memory: iFM word i = i+1 (i=0..449), kernel words 3,4,5,...,38, oFM words 0; defaults.
//  - Reset 4 cycles, start -> pl_status[0] rises; word 486 (byte 1944) = 36471 (oFM[0][0][0]).
//  - Same run: word 487 = 36678 (oFM[0][0][1]); word 655 = 78429 (oFM[1][0][0]).
//  - Same run: words 0..485 unchanged; exactly 338 write cycles, all with we=4'hF.
//  - Hold start high after done -> pl_status stays 1, no new writes; drop start -> pl_status 0 next cycles.
//  - Assert reset mid-run -> all outputs 0 at once; restart completes with identical oFM contents.

Source files
------------

// File: rtl/std_conv.sv
// ============================================================================
//  std_conv : dense valid-mode 2-D convolution engine, single 32-bit BRAM port
//  Revision : 1.0
// ============================================================================
`default_nettype none

module std_conv #(
  parameter int N         = 2,
  parameter int M         = 2,
  parameter int K         = 3,
  parameter int IFM_R     = 15,
  parameter int IFM_C     = 15,
  parameter int OFM_R     = IFM_R - K + 1,
  parameter int OFM_C     = IFM_C - K + 1,
  parameter int IFM_BASE  = 0,
  parameter int KERN_BASE = IFM_BASE + N * IFM_R * IFM_C,
  parameter int OFM_BASE  = KERN_BASE + K * K * M * N
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic [31:0] BRAM_addr,
  input  logic [31:0] BRAM_rddata,
  output logic [31:0] BRAM_wrdata,
  output logic [3:0]  BRAM_we
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_IFM = 3'd1;
  localparam logic [2:0] ST_RD_W   = 3'd2;
  localparam logic [2:0] ST_CAP    = 3'd3;
  localparam logic [2:0] ST_MAC    = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam logic [15:0] C_N_LAST = 16'(N - 1);
  localparam logic [15:0] C_M_LAST = 16'(M - 1);
  localparam logic [15:0] C_K_LAST = 16'(K - 1);
  localparam logic [15:0] C_R_LAST = 16'(OFM_R - 1);
  localparam logic [15:0] C_C_LAST = 16'(OFM_C - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] m_q, m_d, r_q, r_d, c_q, c_d;
  logic [15:0] n_q, n_d, i_q, i_d, j_q, j_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] pix_q, pix_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic [3:0]  we_q, we_d;
  logic        done_q, done_d;

  logic        start;
  logic        last_tap;
  logic        last_pix;
  logic [31:0] ifm_addr;
  logic [31:0] kern_addr;
  logic [31:0] ofm_addr;
  logic [31:0] prod;
  logic        unused_ctrl;

  assign start       = ps_control[0];
  assign unused_ctrl = ^ps_control[31:1];

  assign last_tap = (n_q == C_N_LAST) && (i_q == C_K_LAST) && (j_q == C_K_LAST);
  assign last_pix = (m_q == C_M_LAST) && (r_q == C_R_LAST) && (c_q == C_C_LAST);

  // Byte addresses of the current tap operands and the current output pixel.
  assign ifm_addr  = (32'(IFM_BASE) + (32'(n_q) * 32'(IFM_R) + 32'(r_q) + 32'(i_q)) * 32'(IFM_C)
                      + 32'(c_q) + 32'(j_q)) << 2;
  assign kern_addr = (32'(KERN_BASE) + ((32'(m_q) * 32'(N) + 32'(n_q)) * 32'(K) + 32'(i_q)) * 32'(K)
                      + 32'(j_q)) << 2;
  assign ofm_addr  = (32'(OFM_BASE) + (32'(m_q) * 32'(OFM_R) + 32'(r_q)) * 32'(OFM_C)
                      + 32'(c_q)) << 2;

  assign prod = pix_q * BRAM_rddata;

  assign pl_status   = {31'b0, done_q};
  assign BRAM_addr   = addr_q;
  assign BRAM_wrdata = wrdata_q;
  assign BRAM_we     = we_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      pix_q    <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      we_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      r_q      <= r_d;
      c_q      <= c_d;
      n_q      <= n_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      pix_q    <= pix_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      we_q     <= we_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RD_IFM;
      ST_RD_IFM: state_d = ST_RD_W;
      ST_RD_W:   state_d = ST_CAP;
      ST_CAP:    state_d = ST_MAC;
      ST_MAC:    state_d = last_tap ? ST_WRITE : ST_RD_IFM;
      ST_WRITE:  state_d = last_pix ? ST_DONE : ST_RD_IFM;
      ST_DONE:   if (!start) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Read latency: address registered in RD_IFM/RD_W, iFM word arrives in CAP,
  // kernel word arrives in MAC.
  always_comb begin
    m_d      = m_q;
    r_d      = r_q;
    c_d      = c_q;
    n_d      = n_q;
    i_d      = i_q;
    j_d      = j_q;
    acc_d    = acc_q;
    pix_d    = pix_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    we_d     = 4'h0;
    done_d   = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        m_d   = '0;
        r_d   = '0;
        c_d   = '0;
        n_d   = '0;
        i_d   = '0;
        j_d   = '0;
        acc_d = '0;
      end
      ST_RD_IFM: addr_d = ifm_addr;
      ST_RD_W:   addr_d = kern_addr;
      ST_CAP:    pix_d  = BRAM_rddata;
      ST_MAC: begin
        acc_d = acc_q + prod;
        if (j_q == C_K_LAST) begin
          j_d = '0;
          if (i_q == C_K_LAST) begin
            i_d = '0;
            n_d = (n_q == C_N_LAST) ? '0 : n_q + 16'd1;
          end else begin
            i_d = i_q + 16'd1;
          end
        end else begin
          j_d = j_q + 16'd1;
        end
      end
      ST_WRITE: begin
        addr_d   = ofm_addr;
        wrdata_d = acc_q;
        we_d     = 4'hF;
        acc_d    = '0;
        if (c_q == C_C_LAST) begin
          c_d = '0;
          if (r_q == C_R_LAST) begin
            r_d = '0;
            m_d = (m_q == C_M_LAST) ? '0 : m_q + 16'd1;
          end else begin
            r_d = r_q + 16'd1;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_std_conv.sv
// ============================================================================
//  tb_std_conv : directed self-checking bench for std_conv with a BRAM model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_std_conv;

  localparam int IFM_WORDS = 450;
  localparam int KERN_BASE = 450;
  localparam int OFM_BASE  = 486;
  localparam int OFM_WORDS = 338;
  localparam int OFM_END   = OFM_BASE + OFM_WORDS;
  localparam int TIMEOUT   = 40000;

  logic        clk;
  logic        reset;
  logic [31:0] ps_control;
  logic [31:0] pl_status;
  logic [31:0] BRAM_addr;
  logic [31:0] BRAM_rddata;
  logic [31:0] BRAM_wrdata;
  logic [3:0]  BRAM_we;

  logic [31:0] mem [0:1023];
  logic        init_mem;
  logic        clr_ofm;
  int          wr_count;
  int          bad_we;
  int          oob;

  logic [31:0] exp_ofm [0:OFM_WORDS-1];

  int tests;
  int failed;

  typedef struct {
    string       name;
    int          word;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:7];

  std_conv dut (
    .clk        (clk),
    .reset      (reset),
    .ps_control (ps_control),
    .pl_status  (pl_status),
    .BRAM_addr  (BRAM_addr),
    .BRAM_rddata(BRAM_rddata),
    .BRAM_wrdata(BRAM_wrdata),
    .BRAM_we    (BRAM_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM: data for the address sampled at an edge is visible after it.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 1024; k++)
        mem[k] <= (k < IFM_WORDS) ? 32'(k + 1) : (k < OFM_BASE) ? 32'(k - KERN_BASE + 3) : 32'd0;
      wr_count <= 0;
      bad_we   <= 0;
      oob      <= 0;
    end else if (clr_ofm) begin
      for (int k = OFM_BASE; k < OFM_END; k++) mem[k] <= 32'd0;
      wr_count <= 0;
      bad_we   <= 0;
      oob      <= 0;
    end else begin
      if (BRAM_we == 4'hF) begin
        wr_count <= wr_count + 1;
        if (BRAM_addr[31:2] < 30'(OFM_BASE) || BRAM_addr[31:2] >= 30'(OFM_END) || BRAM_addr[1:0] != 2'b00)
          oob <= oob + 1;
        else
          mem[BRAM_addr[11:2]] <= BRAM_wrdata;
      end else if (BRAM_we != 4'h0) begin
        bad_we <= bad_we + 1;
      end
    end
    BRAM_rddata <= mem[BRAM_addr[11:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < TIMEOUT && !seen; t++) begin
      @(negedge clk);
      if (pl_status[0]) seen = 1'b1;
    end
    check(name, {31'b0, seen}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_ofm_all(input string name);
    int mism;
    mism = 0;
    for (int k = 0; k < OFM_WORDS; k++)
      if (mem[OFM_BASE + k] !== exp_ofm[k]) mism++;
    check(name, 32'(mism), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_status"}, pl_status, 32'd0);
    check({tag, "_addr"}, BRAM_addr, 32'd0);
    check({tag, "_wrdata"}, BRAM_wrdata, 32'd0);
    check({tag, "_we"}, {28'b0, BRAM_we}, 32'd0);
  endtask

  initial begin
    int hold_bad;
    int wc;
    tests  = 0;
    failed = 0;

    // Reference oFM from the convolution definition (int arithmetic wraps mod 2^32).
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 13; r++)
        for (int c = 0; c < 13; c++) begin
          int acc;
          acc = 0;
          for (int n = 0; n < 2; n++)
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                acc += ((n * 15 + r + i) * 15 + c + j + 1) * ((((m * 2 + n) * 3 + i) * 3 + j) + 3);
          exp_ofm[(m * 13 + r) * 13 + c] = 32'(acc);
        end

    vecs[0] = '{"ofm_0_0_0", 486, 32'd36471};
    vecs[1] = '{"ofm_0_0_1", 487, 32'd36678};
    vecs[2] = '{"ofm_1_0_0", 655, 32'd78429};
    vecs[3] = '{"ifm_first", 0, 32'd1};
    vecs[4] = '{"ifm_last", 449, 32'd450};
    vecs[5] = '{"kern_first", 450, 32'd3};
    vecs[6] = '{"kern_last", 485, 32'd38};
    vecs[7] = '{"past_ofm", 824, 32'd0};

    init_mem   = 1'b1;
    clr_ofm    = 1'b0;
    ps_control = 32'd0;
    reset      = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    init_mem = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_status", pl_status, 32'd0);

    ps_control = 32'hFFFF_FFF1;
    wait_done("run1_done");

    for (int v = 0; v < 8; v++)
      check(vecs[v].name, mem[vecs[v].word], vecs[v].exp);
    check("run1_writes", 32'(wr_count), 32'd338);
    check("run1_bad_we", 32'(bad_we), 32'd0);
    check("run1_out_of_region", 32'(oob), 32'd0);
    check_ofm_all("run1_ofm_all");
    begin
      int ro;
      ro = 0;
      for (int k = 0; k < OFM_BASE; k++)
        if (mem[k] !== ((k < IFM_WORDS) ? 32'(k + 1) : 32'(k - KERN_BASE + 3))) ro++;
      check("inputs_unchanged", 32'(ro), 32'd0);
    end

    // Start held high after completion: no restart, status stays up.
    wc       = wr_count;
    hold_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pl_status !== 32'd1) hold_bad++;
    end
    check("hold_status", 32'(hold_bad), 32'd0);
    check("hold_no_writes", 32'(wr_count), 32'(wc));
    ps_control = 32'd0;
    repeat (3) @(negedge clk);
    check("status_cleared", pl_status, 32'd0);

    // Restart, then abort with an asynchronous reset partway through.
    clr_ofm = 1'b1;
    @(negedge clk);
    clr_ofm    = 1'b0;
    ps_control = 32'd1;
    repeat (500) @(negedge clk);
    check("midrun_writing", {31'b0, (wr_count > 0)}, 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_outputs_zero("abort");
    ps_control = 32'd0;
    @(negedge clk);
    clr_ofm = 1'b1;
    @(negedge clk);
    clr_ofm = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    ps_control = 32'd1;
    wait_done("run2_done");
    check("run2_writes", 32'(wr_count), 32'd338);
    check("run2_out_of_region", 32'(oob), 32'd0);
    check_ofm_all("run2_ofm_all");
    check("run2_ofm_0_0_0", mem[486], 32'd36471);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
